slice_scheduler: RTL

//  Derives slice timing from the rotation (hall) sensor: measures revolution period in clk_33 cycles,

---
 rtl/slice_sched_pkg.sv | 20 ++
 rtl/slice_scheduler_hall_edge_sync.sv | 33 +++
 rtl/slice_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/slice_sched_pkg.sv
// Shared types and constants for the slice scheduler.
// Holds the FSM state encoding, the driver frame length and a slice-index width helper.
package slice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_e;

  // One LED driver frame per slice; the shortest revolution we accept
  // gives every slice at least one full frame.
  localparam int SLICE_FRAME_CYCLES = 512;

  // Width of a slice index, at least one bit.
  function automatic int idWidth(input int nbSlices);
    return (nbSlices > 1) ? $clog2(nbSlices) : 1;
  endfunction

endpackage

// File: rtl/slice_scheduler_hall_edge_sync.sv
// Hall sensor front end: brings the asynchronous hall_in into the clock
// domain with a two-flop synchroniser, then flags its rising edge as a
// one-cycle hall_edge_o pulse.
module hall_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hall_i,
  output logic hall_edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_q;

  // Synchronise the sensor and register a pulse on every 0->1 transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign hall_edge_o = edge_q;

endmodule

// File: rtl/slice_scheduler.sv
// Slice scheduler: measures the revolution period from the hall sensor and
// cuts each revolution into NB_SLICES slices using a Bresenham accumulator,
// so no divider is needed. Emits a one-cycle slice_sync at the start of each
// slice together with the slice index.
// Optional feature: define SLICE_OFFSET_EN to add the slice_offset input,
// which rotates the reported slice_id by a constant number of slices.
module slice_scheduler
  import slice_sched_pkg::*;
#(
  parameter  int NB_SLICES  = 128,
  parameter  int PERIOD_W   = 24,
  parameter  int MIN_PERIOD = NB_SLICES * SLICE_FRAME_CYCLES,
  localparam int ID_W       = idWidth(NB_SLICES)
) (
  input  logic                clk_33,
  input  logic                rst,
  input  logic                hall_in,
`ifdef SLICE_OFFSET_EN
  input  logic [ID_W-1:0]     slice_offset,
`endif
  output logic                slice_sync,
  output logic [ID_W-1:0]     slice_id,
  output logic                locked,
  output logic [PERIOD_W-1:0] period,
  output logic                err_fast
);

  localparam int                  ACC_W   = PERIOD_W + 1;
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [ACC_W-1:0]    STEP    = ACC_W'(NB_SLICES);
  localparam logic [ID_W-1:0]     LAST_ID = ID_W'(NB_SLICES - 1);

  logic hallEdge;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                sync_q, sync_d;
  logic                locked_q, locked_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                errFast_q, errFast_d;

  logic                cntSat;
  logic [PERIOD_W-1:0] cntInc;
  logic [ACC_W-1:0]    accSum;
  logic                advance;
  logic                edgeValid;

  hall_edge_sync uHallSync (
    .clk_i       (clk_33),
    .rst_i       (rst),
    .hall_i      (hall_in),
    .hall_edge_o (hallEdge)
  );

  // cntInc is the cycle count including the current cycle, so an edge
  // arriving N cycles after the previous one measures a period of exactly N.
  assign cntSat    = (cnt_q == CNT_MAX);
  assign cntInc    = cntSat ? cnt_q : cnt_q + 1'b1;
  assign accSum    = acc_q + STEP;
  assign advance   = (accSum >= {1'b0, period_q});
  assign edgeValid = hallEdge && (cntInc >= MIN_P);

  // Next-state logic: revolution measurement, lock tracking and slice stepping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cntInc;
    acc_d     = acc_q;
    id_d      = id_q;
    sync_d    = 1'b0;
    locked_d  = locked_q;
    period_d  = period_q;
    errFast_d = errFast_q;
    case (state_q)
      IDLE: begin
        locked_d = 1'b0;
        if (hallEdge) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        if (hallEdge) begin
          cnt_d = '0;
          if (edgeValid) begin
            state_d  = RUN;
            locked_d = 1'b1;
            period_d = cntInc;
            acc_d    = '0;
            id_d     = '0;
            sync_d   = 1'b1;
          end else begin
            errFast_d = 1'b1;
          end
        end else if (cntSat) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (edgeValid) begin
          // A fresh revolution always restarts at slice 0, even if the
          // accumulator wanted to advance in the same cycle.
          period_d = cntInc;
          cnt_d    = '0;
          acc_d    = '0;
          id_d     = '0;
          sync_d   = 1'b1;
        end else begin
          // A too-early edge is treated as noise: flagged, otherwise ignored.
          if (hallEdge) begin
            errFast_d = 1'b1;
          end
          if (cntSat) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            id_d     = '0;
            acc_d    = '0;
          end else if (advance) begin
            // On the last slice the rotor is slower than the last measurement;
            // wait there for the next hall edge instead of wrapping.
            if (id_q != LAST_ID) begin
              acc_d  = accSum - {1'b0, period_q};
              id_d   = id_q + 1'b1;
              sync_d = 1'b1;
            end
          end else begin
            acc_d = accSum;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_33) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      id_q      <= '0;
      sync_q    <= 1'b0;
      locked_q  <= 1'b0;
      period_q  <= '0;
      errFast_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      id_q      <= id_d;
      sync_q    <= sync_d;
      locked_q  <= locked_d;
      period_q  <= period_d;
      errFast_q <= errFast_d;
    end
  end

  assign slice_sync = sync_q;
  assign locked     = locked_q;
  assign period     = period_q;
  assign err_fast   = errFast_q;

`ifdef SLICE_OFFSET_EN
  localparam int               ID_W1 = ID_W + 1;
  localparam logic [ID_W1-1:0] NB_W  = ID_W1'(NB_SLICES);

  logic [ID_W1-1:0] offRed;
  logic [ID_W1-1:0] idSum;
  logic [ID_W-1:0]  idOut_q;

  // Rotate the next slice index by the offset, modulo NB_SLICES, without a divider.
  always_comb begin
    offRed = {1'b0, slice_offset};
    if (offRed >= NB_W) begin
      offRed = offRed - NB_W;
    end
    idSum = {1'b0, id_d} + offRed;
    if (idSum >= NB_W) begin
      idSum = idSum - NB_W;
    end
  end

  // Register the rotated index alongside the internal one so it moves with slice_sync.
  always_ff @(posedge clk_33) begin
    if (rst) begin
      idOut_q <= '0;
    end else begin
      idOut_q <= idSum[ID_W-1:0];
    end
  end

  assign slice_id = idOut_q;
`else
  assign slice_id = id_q;
`endif

endmodule
